// File: rtl/lf_pg_stage.sv
// Operand-entry stage of the Ladner-Fischer adder: bitwise propagate/generate with cin
// folded into bit 0, behind a 2-entry skid buffer (main M drives outputs, skid S absorbs stalls).

module lf_pg_cell (
    input  logic a,
    input  logic b,
    output logic p,
    output logic g
);
    assign p = a ^ b;
    assign g = a & b;
endmodule

module lf_pg_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p_list,
    output logic [WIDTH-1:0] g_list,
    output logic [WIDTH-1:0] p_sum,
    output logic             cin_out
);
    if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_width_chk
        $error("lf_pg_stage: WIDTH must be even and >= 4");
    end

    typedef struct packed {
        logic [WIDTH-1:0] p_list;
        logic [WIDTH-1:0] g_list;
        logic [WIDTH-1:0] p_sum;
        logic             cin;
    } pg_word_t;

    logic [WIDTH-1:0] p, g;
    pg_word_t         w_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        lf_pg_cell u_cell (.a(a[i]), .b(b[i]), .p(p[i]), .g(g[i]));
    end

    // cin enters the tree as an extra generate at bit 0
    always_comb begin
        w_in        = '0;
        w_in.p_list = p;
        w_in.g_list = {g[WIDTH-1:1], g[0] | (p[0] & cin)};
        w_in.p_sum  = p;
        w_in.cin    = cin;
    end

    pg_word_t m_q, s_q, m_d, s_d;
    logic     m_full, s_full, m_full_d, s_full_d;
    logic     in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_full & out_ready;

    always_comb begin
        m_d      = m_q;
        s_d      = s_q;
        m_full_d = m_full;
        s_full_d = s_full;
        if (!m_full || out_fire) begin
            if (s_full) begin
                m_d      = s_q;
                m_full_d = 1'b1;
                if (in_fire) s_d = w_in;
                else         s_full_d = 1'b0;
            end else if (in_fire) begin
                m_d      = w_in;
                m_full_d = 1'b1;
            end else begin
                m_full_d = 1'b0;
            end
        end else if (in_fire) begin
            // M is stalled; in_ready guarantees S is free here
            s_d      = w_in;
            s_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q      <= '0;
            s_q      <= '0;
            m_full   <= 1'b0;
            s_full   <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            m_q      <= m_d;
            s_q      <= s_d;
            m_full   <= m_full_d;
            s_full   <= s_full_d;
            in_ready <= !s_full_d;
        end
    end

    assign out_valid = m_full;
    assign p_list    = m_q.p_list;
    assign g_list    = m_q.g_list;
    assign p_sum     = m_q.p_sum;
    assign cin_out   = m_q.cin;
endmodule

// File: tb/tb_lf_pg_stage.sv
// Directed and streaming checks for lf_pg_stage: reset, PG values, cin fold, skid backpressure,
// throughput and randomly stalled ordering against a reference queue.

module tb_lf_pg_stage;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         out_valid, out_ready = 1'b0;
    logic [W-1:0] p_list, g_list, p_sum;
    logic         cin_out;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;

    lf_pg_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .p_list(p_list), .g_list(g_list), .p_sum(p_sum), .cin_out(cin_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3*W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W-1:0] pp, gg;
        pp = x ^ y;
        gg = x & y;
        gg[0] = gg[0] | (pp[0] & c);
        return {pp, gg, pp, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a = x; b = y; cin = c;
    endtask

    // Scoreboard monitor, sampled on the falling edge while streaming tests run
    logic [3*W:0] sb[$];
    logic [3*W:0] held;
    logic         hold = 1'b0;
    logic         mon_en = 1'b0;
    int           n_out = 0, first_in = -1, first_out = -1, last_out = -1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, cin));
                if (first_in < 0) first_in = cyc;
            end
            if (hold) chk("stable", {p_list, g_list, p_sum, cin_out}, held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else chk("sb_word", {p_list, g_list, p_sum, cin_out}, sb.pop_front());
                n_out++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            hold = out_valid && !out_ready;
            held = {p_list, g_list, p_sum, cin_out};
        end
    end

    task automatic stream(input int nwords, input bit rnd, input int budget);
        int  sent = 0, c = 0;
        bit  fire;
        in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        set_word($urandom, $urandom, 1'($urandom_range(0, 1)));
        while (sent < nwords && c < budget) begin
            fire = in_valid && in_ready;
            tick();
            c++;
            if (fire) sent++;
            if (fire || !in_valid) set_word($urandom, $urandom, 1'($urandom_range(0, 1)));
            in_valid  = (sent < nwords) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (c >= budget) chk("stream_timeout", sent, nwords);
        in_valid = 1'b0;
        c = 0;
        while ((sb.size() != 0 || out_valid) && c < 500) begin
            tick();
            c++;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (c >= 500) chk("drain_timeout", sb.size(), 0);
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outputs", {p_list, g_list, p_sum, cin_out}, 0);
        rst = 1'b0;
        tick();

        // Single word, 1-cycle latency
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_word(32'h0000_000F, 32'h0000_0001, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1);
        chk("single_p_list", p_list, 32'h0000_000E);
        chk("single_g_list", g_list, 32'h0000_0001);
        chk("single_p_sum", p_sum, 32'h0000_000E);
        chk("single_cin_out", cin_out, 1);
        tick();
        chk("single_drain", out_valid, 0);

        // cin folding into bit 0
        in_valid = 1'b1;
        set_word(32'h0000_0001, 32'h0, 1'b1);
        tick();
        chk("fold1_g_list", g_list, 32'h0000_0001);
        chk("fold1_p_list", p_list, 32'h0000_0001);
        set_word(32'h0000_0001, 32'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("fold0_g_list", g_list, 32'h0);
        chk("fold0_p_list", p_list, 32'h0000_0001);
        chk("fold0_cin_out", cin_out, 0);
        tick();

        // Backpressure: W0 -> M, W1 -> S, W2 held off until release
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_word(32'h1111_0000, 32'h0101_0101, 1'b0);
        tick();
        chk("bp_w0_in_m", p_list, 32'h1010_0101);
        chk("bp_ready_after_w0", in_ready, 1);
        set_word(32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1);
        tick();
        chk("bp_ready_low", in_ready, 0);
        set_word(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
        tick();
        chk("bp_w0_held", {p_list, g_list, p_sum, cin_out}, model(32'h1111_0000, 32'h0101_0101, 1'b0));
        chk("bp_ready_still_low", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("bp_w1_out", {out_valid, p_list, g_list, p_sum, cin_out},
            {1'b1, model(32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1)});
        chk("bp_ready_back", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_w2_out", {out_valid, p_list, g_list, p_sum, cin_out},
            {1'b1, model(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1)});
        tick();
        chk("bp_empty", out_valid, 0);

        // Reset with both M and S full
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_word(32'h1234_5678, 32'h8765_4321, 1'b1);
        tick();
        tick();
        in_valid = 1'b0;
        chk("mid_full", {out_valid, in_ready}, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_outputs", {p_list, g_list, p_sum, cin_out}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Full throughput
        mon_en = 1'b1;
        stream(100, 1'b0, 300);
        chk("tput_count", n_out, 100);
        chk("tput_latency", first_out - first_in, 1);
        chk("tput_span", last_out - first_out, 99);

        // Random stall, ordering and stability
        n_out = 0;
        stream(10000, 1'b1, 80000);
        chk("stall_count", n_out, 10000);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
